// File: rtl/instr_fetch.sv
// -----------------------------------------------------------------------------
// instr_fetch
//
// Instruction fetch stage with a 2-entry prefetch FIFO. The fetch PC drives a
// combinational instruction memory; each word returned is pushed into the
// FIFO together with its address whenever there is room (or the head is being
// consumed in the same cycle). Decode consumes the FIFO head through a
// valid/ready handshake. A redirect (branch/jump) flushes the FIFO and
// restarts fetch at the word-aligned target. Misaligned targets raise a
// one-cycle error pulse.
//
// Ports:
//   clk             rising-edge clock
//   rst_n           asynchronous active-low reset
//   im_adress       byte address to instruction memory (= fetch PC)
//   im_instruction  instruction word returned for im_adress
//   redirect_valid  one-cycle request to restart fetch at redirect_pc
//   redirect_pc     redirect target address
//   if_valid        FIFO head valid toward decode
//   if_ready        decode accepts the head when if_valid && if_ready
//   if_instr        head-entry instruction
//   if_pc           head-entry address
//   err_misaligned  pulse: accepted redirect target had non-zero bits [1:0]
//   fetch_count     number of words pushed since reset (wraps at 2^32)
// -----------------------------------------------------------------------------
module instr_fetch #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          MEM_BYTES = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] im_adress,
    input  logic [31:0] im_instruction,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    output logic        err_misaligned,
    output logic [31:0] fetch_count
);

    // Fetch addresses wrap modulo the memory size, which is a power of two.
    localparam logic [31:0] ADDR_MASK = 32'(MEM_BYTES - 1);

    logic [31:0] pc;
    logic [1:0]  count;
    logic [31:0] head_pc;
    logic [31:0] head_instr;
    logic [31:0] tail_pc;
    logic [31:0] tail_instr;

    logic        pop;
    logic        push_en;
    logic [31:0] pc_next;
    logic [31:0] redirect_target;

    assign im_adress = pc;
    assign if_valid  = (count != 2'd0);
    assign if_pc     = head_pc;
    assign if_instr  = head_instr;

    // A push is allowed when a slot is free now or will be freed by a pop in
    // the same cycle; a redirect suppresses it because the word is stale.
    always_comb begin
        pop             = if_valid && if_ready;
        push_en         = !redirect_valid && ((count < 2'd2) || pop);
        pc_next         = (pc + 32'd4) & ADDR_MASK;
        redirect_target = {redirect_pc[31:2], 2'b00} & ADDR_MASK;
    end

    // The FIFO is kept as an explicit head/tail pair so the head registers
    // feed decode directly and stay stable while decode stalls. A redirect
    // flushes everything; a pop coincident with it still completes at decode
    // because decode samples the handshake at the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc             <= RESET_PC;
            count          <= 2'd0;
            head_pc        <= 32'd0;
            head_instr     <= 32'd0;
            tail_pc        <= 32'd0;
            tail_instr     <= 32'd0;
            err_misaligned <= 1'b0;
            fetch_count    <= 32'd0;
        end else begin
            err_misaligned <= redirect_valid && (redirect_pc[1:0] != 2'b00);
            if (redirect_valid) begin
                count <= 2'd0;
                pc    <= redirect_target;
            end else begin
                if (push_en) begin
                    pc          <= pc_next;
                    fetch_count <= fetch_count + 32'd1;
                end
                case ({push_en, pop})
                    2'b10: begin
                        if (count == 2'd0) begin
                            head_pc    <= pc;
                            head_instr <= im_instruction;
                        end else begin
                            tail_pc    <= pc;
                            tail_instr <= im_instruction;
                        end
                        count <= count + 2'd1;
                    end
                    2'b01: begin
                        head_pc    <= tail_pc;
                        head_instr <= tail_instr;
                        count      <= count - 2'd1;
                    end
                    2'b11: begin
                        // Occupancy is unchanged; only the contents shift.
                        if (count == 2'd2) begin
                            head_pc    <= tail_pc;
                            head_instr <= tail_instr;
                            tail_pc    <= pc;
                            tail_instr <= im_instruction;
                        end else begin
                            head_pc    <= pc;
                            head_instr <= im_instruction;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule
